// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller (package pipe_pkg).
// Holds the FSM state enum, the default halt opcode and the register-zero constant.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    localparam logic [3:0]  OP_HLT_DEFAULT = 4'b1111;
    localparam logic [3:0]  REG_ZERO       = 4'h0;
    localparam logic [15:0] STALL_CNT_MAX  = 16'hFFFF;

    // A read-after-write match; register zero is hardwired and never conflicts.
    function automatic logic src_match(
        input logic [3:0] src,
        input logic       used,
        input logic [3:0] rd,
        input logic       writes
    );
        return used && writes && (src != REG_ZERO) && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// Carries the hazard/memory/halt inputs and the stage enables, flushes and status.
interface pipe_ctrl_if;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [3:0]  idex_rd;
    logic        idex_regwrite;
    logic        idex_is_load;
    logic [3:0]  exmem_rd;
    logic        exmem_regwrite;
    logic        dmem_req;
    logic        dmem_ready;
    logic        branch_taken;
    logic [3:0]  wb_op;

    logic        pc_we;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_mem_we;
    logic        mem_wb_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used,
        output idex_rd, idex_regwrite, idex_is_load,
        output exmem_rd, exmem_regwrite,
        output dmem_req, dmem_ready, branch_taken, wb_op,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used,
        input  idex_rd, idex_regwrite, idex_is_load,
        input  exmem_rd, exmem_regwrite,
        input  dmem_req, dmem_ready, branch_taken, wb_op,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Combinational RAW detector (module hazard_detect) for the two ID source fields.
// Macro PIPE_CTRL_FWD_EN: forwarding present, so only load-use raises a hazard.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [3:0] id_rs_i,
    input  logic [3:0] id_rt_i,
    input  logic       id_rs_used_i,
    input  logic       id_rt_used_i,
    input  logic [3:0] idex_rd_i,
    input  logic       idex_regwrite_i,
    input  logic       idex_is_load_i,
    input  logic [3:0] exmem_rd_i,
    input  logic       exmem_regwrite_i,
    output logic       hazard_o
);

    logic [3:0] src      [2];
    logic       src_used [2];
    logic [1:0] load_use;

    assign src[0]      = id_rs_i;
    assign src[1]      = id_rt_i;
    assign src_used[0] = id_rs_used_i;
    assign src_used[1] = id_rt_used_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_load_use
            assign load_use[gi] = src_match(src[gi], src_used[gi], idex_rd_i,
                                            idex_regwrite_i & idex_is_load_i);
        end
    endgenerate

`ifdef PIPE_CTRL_FWD_EN
    // EX/MEM results are forwarded; the MEM destination can never cause a stall.
    logic unused_exmem;
    assign unused_exmem = ^{exmem_rd_i, exmem_regwrite_i};
    assign hazard_o     = |load_use;
`else
    logic [1:0] idex_raw;
    logic [1:0] exmem_raw;

    for (genvar gi = 0; gi < 2; gi++) begin : g_raw
        assign idex_raw[gi]  = src_match(src[gi], src_used[gi], idex_rd_i, idex_regwrite_i);
        assign exmem_raw[gi] = src_match(src[gi], src_used[gi], exmem_rd_i, exmem_regwrite_i);
    end

    assign hazard_o = (|load_use) | (|idex_raw) | (|exmem_raw);
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller: RUN / MEM_WAIT / HALT FSM plus stall counter.
// Macro PIPE_CTRL_FWD_EN selects the forwarding-aware hazard rule in hazard_detect.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter logic [3:0] OP_HLT = OP_HLT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_if.slave     bus
);

    pipe_state_e state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic mem_stall;
    logic halt_req;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, halted;

    hazard_detect u_hazard (
        .id_rs_i          (bus.id_rs),
        .id_rt_i          (bus.id_rt),
        .id_rs_used_i     (bus.id_rs_used),
        .id_rt_used_i     (bus.id_rt_used),
        .idex_rd_i        (bus.idex_rd),
        .idex_regwrite_i  (bus.idex_regwrite),
        .idex_is_load_i   (bus.idex_is_load),
        .exmem_rd_i       (bus.exmem_rd),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .hazard_o         (hazard)
    );

    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        mem_stall   = 1'b0;
        halt_req    = 1'b0;
        state_d     = state_q;

        if (!rst) begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    // Once waiting, only dmem_ready releases the pipe; the ready cycle is a normal RUN cycle.
                    mem_stall = (state_q == MEM_WAIT) ? !bus.dmem_ready
                                                      : (bus.dmem_req && !bus.dmem_ready);
                    halt_req  = (bus.wb_op == OP_HLT) && !(state_q == MEM_WAIT && mem_stall);

                    if (mem_stall) begin
                        // everything frozen, no bubbles
                    end else if (hazard) begin
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        mem_wb_we   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_we       = 1'b1;
                        if_id_we    = 1'b1;
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        mem_wb_we   = 1'b1;
                        if_id_flush = bus.branch_taken;
                    end

                    if (halt_req) begin
                        state_d = HALT;
                    end else if (mem_stall) begin
                        state_d = MEM_WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != HALT && !pc_we && stall_cnt_q != STALL_CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.if_id_we    = if_id_we;
    assign bus.id_ex_we    = id_ex_we;
    assign bus.ex_mem_we   = ex_mem_we;
    assign bus.mem_wb_we   = mem_wb_we;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.halted      = halted;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset, load-use, memory wait, branch,
// halt, non-forwarding RAW stalls (PIPE_CTRL_FWD_EN aware) and stall_cnt saturation.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.OP_HLT(4'b1111)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb} and {if_id_flush, id_ex_flush}
    wire [4:0] we_v = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we};
    wire [3:0] we_h = {bus.pc_we, bus.if_id_we, bus.ex_mem_we, bus.mem_wb_we};
    wire [1:0] fl_v = {bus.if_id_flush, bus.id_ex_flush};

    task automatic idle();
        bus.id_rs          = 4'h0;
        bus.id_rt          = 4'h0;
        bus.id_rs_used     = 1'b0;
        bus.id_rt_used     = 1'b0;
        bus.idex_rd        = 4'h0;
        bus.idex_regwrite  = 1'b0;
        bus.idex_is_load   = 1'b0;
        bus.exmem_rd       = 4'h0;
        bus.exmem_regwrite = 1'b0;
        bus.dmem_req       = 1'b0;
        bus.dmem_ready     = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.wb_op          = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk);
        bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (we_v !== 5'b00000 || fl_v !== 2'b00 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b fl=%b halted=%b, expected we=00000 fl=00 halted=0",
                     we_v, fl_v, bus.halted);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %h expected 0000", bus.stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (we_v !== 5'b11111 || fl_v !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_branch: got we=%b fl=%b expected we=11111 fl=10", we_v, fl_v);
        end
        @(negedge clk);
        bus.branch_taken = 1'b0;
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_release_cnt: got %h expected 0000", bus.stall_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.idex_is_load  = 1'b1;
        bus.idex_regwrite = 1'b1;
        bus.idex_rd       = 4'h3;
        bus.id_rs         = 4'h3;
        bus.id_rs_used    = 1'b1;
        #1;
        checks++;
        if (we_h !== 4'b0011 || fl_v !== 2'b01) begin
            errors++;
            $display("FAIL load_use_stall: got pc/ifid/exmem/memwb=%b fl=%b expected 0011 fl=01", we_h, fl_v);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL load_use_cnt_before: got %h expected 0000", bus.stall_cnt);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd1 || we_v !== 5'b11111) begin
            errors++;
            $display("FAIL load_use_after: got cnt=%h we=%b expected cnt=0001 we=11111", bus.stall_cnt, we_v);
        end
        // Matching field that is not read, and a register-zero match: neither stalls.
        bus.idex_is_load  = 1'b1;
        bus.idex_regwrite = 1'b1;
        bus.idex_rd       = 4'h3;
        bus.id_rs         = 4'h3;
        bus.id_rs_used    = 1'b0;
        bus.id_rt         = 4'h0;
        #1;
        checks++;
        if (we_v !== 5'b11111 || fl_v !== 2'b00) begin
            errors++;
            $display("FAIL load_use_unused_src: got we=%b fl=%b expected 11111 00", we_v, fl_v);
        end
        bus.idex_rd    = 4'h0;
        bus.id_rt_used = 1'b1;
        #1;
        checks++;
        if (we_v !== 5'b11111 || fl_v !== 2'b00) begin
            errors++;
            $display("FAIL load_use_reg0: got we=%b fl=%b expected 11111 00", we_v, fl_v);
        end
        $display("test_load_use done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.dmem_req   = 1'b1;
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (we_v !== 5'b00000 || fl_v !== 2'b00) begin
                errors++;
                $display("FAIL mem_wait_cycle%0d: got we=%b fl=%b expected 00000 00", i, we_v, fl_v);
            end
            @(negedge clk);
        end
        bus.dmem_ready = 1'b1;
        #1;
        checks++;
        if (we_v !== 5'b11111 || bus.stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mem_wait_ready: got we=%b cnt=%h expected we=11111 cnt=0003", we_v, bus.stall_cnt);
        end
        @(negedge clk);
        bus.dmem_req   = 1'b0;
        bus.dmem_ready = 1'b0;
        #1;
        checks++;
        if (we_v !== 5'b11111 || bus.stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mem_wait_back_run: got we=%b cnt=%h expected we=11111 cnt=0003", we_v, bus.stall_cnt);
        end
        // Enter MEM_WAIT, then abort it with a reset pulse between clock edges.
        bus.dmem_req = 1'b1;
        @(negedge clk);
        bus.dmem_req = 1'b0;
        #1;
        checks++;
        if (we_v !== 5'b00000) begin
            errors++;
            $display("FAIL mem_wait_hold_no_req: got we=%b expected 00000", we_v);
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (we_v !== 5'b11111 || bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mem_wait_async_abort: got we=%b cnt=%h expected we=11111 cnt=0000", we_v, bus.stall_cnt);
        end
        $display("test_mem_wait done");
    endtask

    task automatic test_branch();
        do_reset();
        bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (we_v !== 5'b11111 || fl_v !== 2'b10) begin
            errors++;
            $display("FAIL branch_taken: got we=%b fl=%b expected 11111 10", we_v, fl_v);
        end
        bus.idex_is_load  = 1'b1;
        bus.idex_regwrite = 1'b1;
        bus.idex_rd       = 4'h3;
        bus.id_rs         = 4'h3;
        bus.id_rs_used    = 1'b1;
        #1;
        checks++;
        if (we_h !== 4'b0011 || fl_v !== 2'b01) begin
            errors++;
            $display("FAIL branch_with_load_use: got pc/ifid/exmem/memwb=%b fl=%b expected 0011 01", we_h, fl_v);
        end
        $display("test_branch done");
    endtask

    task automatic test_halt();
        do_reset();
        bus.wb_op = 4'hF;
        #1;
        checks++;
        if (we_v !== 5'b11111 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_issue_cycle: got we=%b halted=%b expected 11111 0", we_v, bus.halted);
        end
        @(negedge clk);
        bus.wb_op = 4'h0;
        for (int i = 0; i < 4; i++) begin
            bus.dmem_req     = (i == 1);
            bus.dmem_ready   = (i == 1);
            bus.branch_taken = (i == 2);
            #1;
            checks++;
            if (bus.halted !== 1'b1 || we_v !== 5'b00000 || fl_v !== 2'b00 || bus.stall_cnt !== 16'd0) begin
                errors++;
                $display("FAIL halt_hold%0d: got halted=%b we=%b fl=%b cnt=%h expected 1 00000 00 0000",
                         i, bus.halted, we_v, fl_v, bus.stall_cnt);
            end
            @(negedge clk);
        end
        idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.halted !== 1'b0 || we_v !== 5'b11111) begin
            errors++;
            $display("FAIL halt_reset_exit: got halted=%b we=%b expected 0 11111", bus.halted, we_v);
        end
        $display("test_halt done");
    endtask

    task automatic test_raw_no_fwd();
        do_reset();
        bus.exmem_rd       = 4'h5;
        bus.exmem_regwrite = 1'b1;
        bus.id_rt          = 4'h5;
        bus.id_rt_used     = 1'b1;
        #1;
`ifndef PIPE_CTRL_FWD_EN
        checks++;
        if (bus.pc_we !== 1'b0 || fl_v !== 2'b01) begin
            errors++;
            $display("FAIL raw_exmem_stall: got pc_we=%b fl=%b expected 0 01", bus.pc_we, fl_v);
        end
`else
        checks++;
        if (bus.pc_we !== 1'b1 || fl_v !== 2'b00) begin
            errors++;
            $display("FAIL raw_exmem_fwd: got pc_we=%b fl=%b expected 1 00", bus.pc_we, fl_v);
        end
`endif
        bus.exmem_rd = 4'h0;
        bus.id_rt    = 4'h0;
        #1;
        checks++;
        if (we_v !== 5'b11111 || fl_v !== 2'b00) begin
            errors++;
            $display("FAIL raw_reg0_no_stall: got we=%b fl=%b expected 11111 00", we_v, fl_v);
        end
        idle();
        bus.idex_rd       = 4'h7;
        bus.idex_regwrite = 1'b1;
        bus.id_rs         = 4'h7;
        bus.id_rs_used    = 1'b1;
        #1;
`ifndef PIPE_CTRL_FWD_EN
        checks++;
        if (bus.pc_we !== 1'b0 || fl_v !== 2'b01) begin
            errors++;
            $display("FAIL raw_idex_stall: got pc_we=%b fl=%b expected 0 01", bus.pc_we, fl_v);
        end
`else
        checks++;
        if (bus.pc_we !== 1'b1 || fl_v !== 2'b00) begin
            errors++;
            $display("FAIL raw_idex_fwd: got pc_we=%b fl=%b expected 1 00", bus.pc_we, fl_v);
        end
`endif
        $display("test_raw_no_fwd done");
    endtask

    task automatic test_saturation();
        do_reset();
        bus.dmem_req   = 1'b1;
        bus.dmem_ready = 1'b0;
        repeat (65534) @(negedge clk);
        #1;
        checks++;
        if (bus.stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: got %h expected fffe", bus.stall_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h expected ffff", bus.stall_cnt);
        end
        $display("test_saturation done");
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_halt();
        test_raw_no_fwd();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
